// File: rtl/ram256x16_arbiter_if.sv
// Two-requester RAM bus: port A/B request side plus the RAM-facing side.
interface ram256x16_arbiter_if;
   logic        a_req;
   logic        b_req;
   logic        a_we;
   logic        b_we;
   logic        a_lock;
   logic        b_lock;
   logic [7:0]  a_addr;
   logic [7:0]  b_addr;
   logic [15:0] a_wd;
   logic [15:0] b_wd;
   logic        a_gnt;
   logic        b_gnt;
   logic        a_rvalid;
   logic        b_rvalid;
   logic [15:0] rdata;
   logic        wen;
   logic        ren;
   logic [7:0]  waddr;
   logic [7:0]  raddr;
   logic [15:0] wd;
   logic [15:0] rd;

   modport slave (
      input  a_req, b_req, a_we, b_we, a_lock, b_lock,
      input  a_addr, b_addr, a_wd, b_wd, rd,
      output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
      output wen, ren, waddr, raddr, wd
   );

   modport master (
      output a_req, b_req, a_we, b_we, a_lock, b_lock,
      output a_addr, b_addr, a_wd, b_wd, rd,
      input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
      input  wen, ren, waddr, raddr, wd
   );
endinterface

// File: rtl/ram256x16_arbiter.sv
// Two-port arbiter in front of a single-port 256x16 RAM with registered read data.
// Round-robin or fixed A-priority, plus a bounded lock for read-modify-write.
//
// state | meaning
// IDLE  | no owner, normal arbitration between A and B
// OWN_A | A holds the RAM under lock, B is never granted
// OWN_B | B holds the RAM under lock, A is never granted
module ram256x16_arbiter #(
   parameter int          FIXED_PRIO = 0,
   parameter int unsigned LOCK_MAX   = 15
) (
   input logic                 rwclk,
   input logic                 reset,
   ram256x16_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

   state_t      state_q, state_d;
   logic        last_q, last_d;          // 1 = B was granted last
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic [7:0]  cnt_inc;
   logic        rvalid_a_q, rvalid_b_q;
   logic        gnt_a, gnt_b;

   assign cnt_inc = (lock_cnt_q == 8'hFF) ? lock_cnt_q : lock_cnt_q + 8'd1;

   // Grant selection: lock owner first, then priority / round-robin.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!reset) begin
         case (state_q)
            OWN_A: gnt_a = bus.a_req;
            OWN_B: gnt_b = bus.b_req;
            default: begin
               if (bus.a_req && bus.b_req) begin
                  if (FIXED_PRIO != 0 || last_q) gnt_a = 1'b1;
                  else                          gnt_b = 1'b1;
               end else begin
                  gnt_a = bus.a_req;
                  gnt_b = bus.b_req;
               end
            end
         endcase
      end
   end

   // Lock FSM next state; the owner drops the lock on any cycle with its LOCK low,
   // which covers both "granted without lock" and "idle without lock".
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;
      if (gnt_a)      last_d = 1'b0;
      else if (gnt_b) last_d = 1'b1;
      case (state_q)
         IDLE: begin
            lock_cnt_d = 8'd0;
            if (gnt_a && bus.a_lock)      state_d = OWN_A;
            else if (gnt_b && bus.b_lock) state_d = OWN_B;
         end
         OWN_A: begin
            lock_cnt_d = cnt_inc;
            if (cnt_inc >= LOCK_LIMIT) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end else if (!bus.a_lock) begin
               state_d = IDLE;
            end
         end
         OWN_B: begin
            lock_cnt_d = cnt_inc;
            if (cnt_inc >= LOCK_LIMIT) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end else if (!bus.b_lock) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, round-robin pointer, lock counter and read-valid pipeline.
   always_ff @(posedge rwclk) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         lock_cnt_q <= 8'd0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
         rvalid_a_q <= gnt_a & ~bus.a_we;
         rvalid_b_q <= gnt_b & ~bus.b_we;
      end
   end

   // RAM-side command mux; everything parks at zero when nobody is granted.
   always_comb begin
      bus.a_gnt = gnt_a;
      bus.b_gnt = gnt_b;
      bus.wen   = (gnt_a & bus.a_we) | (gnt_b & bus.b_we);
      bus.ren   = (gnt_a & ~bus.a_we) | (gnt_b & ~bus.b_we);
      bus.waddr = 8'd0;
      bus.wd    = 16'd0;
      if (gnt_a)      bus.waddr = bus.a_addr;
      else if (gnt_b) bus.waddr = bus.b_addr;
      bus.raddr = bus.waddr;
      if (gnt_a && bus.a_we)      bus.wd = bus.a_wd;
      else if (gnt_b && bus.b_we) bus.wd = bus.b_wd;
   end

   // Read return path; valid is masked while reset is held.
   always_comb begin
      bus.a_rvalid = rvalid_a_q & ~reset;
      bus.b_rvalid = rvalid_b_q & ~reset;
      bus.rdata    = (bus.a_rvalid || bus.b_rvalid) ? bus.rd : 16'd0;
   end

endmodule

// File: tb/tb_ram256x16_arbiter.sv
// Bench for ram256x16_arbiter: a round-robin instance (LOCK_MAX=3) and a fixed-priority
// instance (LOCK_MAX=5) share one stimulus; each has its own RAM and reference model.
module tb_ram256x16_arbiter;

   logic        rwclk = 1'b0;
   logic        reset;
   logic        a_req, b_req, a_we, b_we, a_lock, b_lock;
   logic [7:0]  a_addr, b_addr;
   logic [15:0] a_wd, b_wd;

   logic        o_a_gnt [2];
   logic        o_b_gnt [2];
   logic        o_a_rv  [2];
   logic        o_b_rv  [2];
   logic        o_wen   [2];
   logic        o_ren   [2];
   logic [7:0]  o_waddr [2];
   logic [7:0]  o_raddr [2];
   logic [15:0] o_wd    [2];
   logic [15:0] o_rdata [2];

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // reference model state: owner 0=none 1=A 2=B, last 1=A 2=B
   int          m_own  [2];
   int          m_last [2];
   int          m_cnt  [2];
   bit          m_pa   [2];
   bit          m_pb   [2];
   logic [15:0] m_pd   [2];
   logic [15:0] shm    [2][256];
   int          lim    [2] = '{3, 5};
   bit          fp     [2] = '{1'b0, 1'b1};

   always #5 rwclk = ~rwclk;

   for (genvar g = 0; g < 2; g++) begin : inst
      ram256x16_arbiter_if ifc ();
      logic [15:0] ram [256] = '{default: 16'h0};

      assign ifc.a_req  = a_req;
      assign ifc.b_req  = b_req;
      assign ifc.a_we   = a_we;
      assign ifc.b_we   = b_we;
      assign ifc.a_lock = a_lock;
      assign ifc.b_lock = b_lock;
      assign ifc.a_addr = a_addr;
      assign ifc.b_addr = b_addr;
      assign ifc.a_wd   = a_wd;
      assign ifc.b_wd   = b_wd;

      assign o_a_gnt[g] = ifc.a_gnt;
      assign o_b_gnt[g] = ifc.b_gnt;
      assign o_a_rv[g]  = ifc.a_rvalid;
      assign o_b_rv[g]  = ifc.b_rvalid;
      assign o_wen[g]   = ifc.wen;
      assign o_ren[g]   = ifc.ren;
      assign o_waddr[g] = ifc.waddr;
      assign o_raddr[g] = ifc.raddr;
      assign o_wd[g]    = ifc.wd;
      assign o_rdata[g] = ifc.rdata;

      // RAM with registered read data
      always @(posedge rwclk) begin
         if (ifc.wen) ram[ifc.waddr] <= ifc.wd;
         if (ifc.ren) ifc.rd <= ram[ifc.raddr];
      end

      ram256x16_arbiter #(.FIXED_PRIO(g), .LOCK_MAX(g == 0 ? 3 : 5)) dut (
         .rwclk (rwclk),
         .reset (reset),
         .bus   (ifc.slave)
      );
   end

   task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, g, obs, exp);
      end
   endtask

   // 0 = nobody, 1 = A, 2 = B
   function automatic int winner(input int g);
      if (reset) return 0;
      if (m_own[g] == 1) return a_req ? 1 : 0;
      if (m_own[g] == 2) return b_req ? 2 : 0;
      if (a_req && b_req) return (fp[g] || m_last[g] == 2) ? 1 : 2;
      if (a_req) return 1;
      if (b_req) return 2;
      return 0;
   endfunction

   task automatic check_all();
      int          w;
      bit          is_wr;
      logic [7:0]  addr;
      logic [15:0] data;
      bit          rva, rvb;
      if (chk_on) begin
         for (int g = 0; g < 2; g++) begin
            w     = winner(g);
            is_wr = (w == 1 && a_we) || (w == 2 && b_we);
            addr  = (w == 1) ? a_addr : (w == 2) ? b_addr : 8'h00;
            data  = (w == 1) ? a_wd : b_wd;
            chk("a_gnt", g, 32'(o_a_gnt[g]), 32'(w == 1));
            chk("b_gnt", g, 32'(o_b_gnt[g]), 32'(w == 2));
            chk("wen",   g, 32'(o_wen[g]),   32'(is_wr));
            chk("ren",   g, 32'(o_ren[g]),   32'(w != 0 && !is_wr));
            chk("waddr", g, 32'(o_waddr[g]), 32'(addr));
            chk("raddr", g, 32'(o_raddr[g]), 32'(addr));
            if (w == 0)   chk("wd_idle", g, 32'(o_wd[g]), 0);
            else if (is_wr) chk("wd", g, 32'(o_wd[g]), 32'(data));
            rva = m_pa[g] && !reset;
            rvb = m_pb[g] && !reset;
            chk("a_rvalid", g, 32'(o_a_rv[g]), 32'(rva));
            chk("b_rvalid", g, 32'(o_b_rv[g]), 32'(rvb));
            chk("rdata", g, 32'(o_rdata[g]), (rva || rvb) ? 32'(m_pd[g]) : 0);
         end
      end
   endtask

   task automatic model_update(input int g, input int w);
      int held;
      bit held_lock;
      if (reset) begin
         m_own[g] = 0; m_last[g] = 2; m_cnt[g] = 0; m_pa[g] = 0; m_pb[g] = 0;
      end else begin
         m_pa[g] = (w == 1 && !a_we);
         m_pb[g] = (w == 2 && !b_we);
         if (m_pa[g]) m_pd[g] = shm[g][a_addr];
         if (m_pb[g]) m_pd[g] = shm[g][b_addr];
         if (w == 1 && a_we) shm[g][a_addr] = a_wd;
         if (w == 2 && b_we) shm[g][b_addr] = b_wd;
         if (w != 0) m_last[g] = w;
         if (m_own[g] == 0) begin
            if (w == 1 && a_lock)      begin m_own[g] = 1; m_cnt[g] = 0; end
            else if (w == 2 && b_lock) begin m_own[g] = 2; m_cnt[g] = 0; end
         end else begin
            held      = m_own[g];
            held_lock = (held == 1) ? a_lock : b_lock;
            m_cnt[g]  = (m_cnt[g] < 255) ? m_cnt[g] + 1 : 255;
            if (m_cnt[g] >= lim[g]) begin
               m_own[g]  = 0;
               m_last[g] = held;
            end else if ((w == held && !held_lock) ||
                         (!((held == 1) ? a_req : b_req) && !held_lock)) begin
               m_own[g] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      int w [2];
      check_all();
      for (int g = 0; g < 2; g++) w[g] = winner(g);
      @(posedge rwclk);
      for (int g = 0; g < 2; g++) model_update(g, w[g]);
      @(negedge rwclk);
   endtask

   task automatic drive(input bit rst,
                        input bit ar, input bit aw, input bit al, input logic [7:0] aa, input logic [15:0] ad,
                        input bit br, input bit bw, input bit bl, input logic [7:0] ba, input logic [15:0] bd);
      reset = rst;
      a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wd = ad;
      b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wd = bd;
      #1;
   endtask

   initial begin
      for (int g = 0; g < 2; g++)
         for (int i = 0; i < 256; i++) shm[g][i] = 16'h0;

      // initial reset edge, state unknown before it
      drive(1, 0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0);
      tick();
      chk_on = 1'b1;

      // requests are ignored while reset is held
      drive(1, 1,1,0,8'h10,16'hBEEF, 1,0,0,8'h20,16'h0);
      chk("rst_a_gnt", 0, 32'(o_a_gnt[0]), 0);
      chk("rst_wen",   0, 32'(o_wen[0]), 0);
      tick();

      // A writes 0xBEEF to 0x10, then reads it back
      drive(0, 1,1,0,8'h10,16'hBEEF, 0,0,0,8'h00,16'h0);
      chk("wr_a_gnt", 0, 32'(o_a_gnt[0]), 1);
      chk("wr_wen",   0, 32'(o_wen[0]), 1);
      chk("wr_waddr", 0, 32'(o_waddr[0]), 'h10);
      chk("wr_wd",    0, 32'(o_wd[0]), 'hBEEF);
      tick();
      drive(0, 1,0,0,8'h10,16'h0, 0,0,0,8'h00,16'h0);
      chk("rd_ren", 0, 32'(o_ren[0]), 1);
      tick();
      drive(0, 0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0);
      chk("rd_rvalid", 0, 32'(o_a_rv[0]), 1);
      chk("rd_rdata",  0, 32'(o_rdata[0]), 'hBEEF);
      tick();

      // continuous reads from both ports after reset
      drive(1, 0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0);
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1,0,0,8'(i),16'h0, 1,0,0,8'(8'h80 + i),16'h0);
         chk("rr_a_gnt", 0, 32'(o_a_gnt[0]), 32'(i % 2 == 0));
         chk("rr_b_gnt", 0, 32'(o_b_gnt[0]), 32'(i % 2 == 1));
         chk("rr_a_rv",  0, 32'(o_a_rv[0]),  32'(i % 2 == 1));
         chk("rr_b_rv",  0, 32'(o_b_rv[0]),  32'(i > 0 && i % 2 == 0));
         if (i < 4) begin
            chk("fp_a_gnt", 1, 32'(o_a_gnt[1]), 1);
            chk("fp_b_gnt", 1, 32'(o_b_gnt[1]), 0);
         end
         tick();
      end

      // B locked read-modify-write of 0x20 while A waits
      drive(0, 0,0,0,8'h00,16'h0, 1,0,1,8'h20,16'h0);
      for (int g = 0; g < 2; g++) chk("lk_b_rd", g, 32'(o_b_gnt[g]), 1);
      tick();
      drive(0, 1,0,0,8'h30,16'h0, 1,1,0,8'h20,16'h1234);
      for (int g = 0; g < 2; g++) begin
         chk("lk_b_wr", g, 32'(o_b_gnt[g]), 1);
         chk("lk_a_blk", g, 32'(o_a_gnt[g]), 0);
      end
      tick();
      drive(0, 1,0,0,8'h30,16'h0, 0,0,0,8'h00,16'h0);
      for (int g = 0; g < 2; g++) chk("lk_a_after", g, 32'(o_a_gnt[g]), 1);
      tick();

      // A holds its lock with continuous requests, B keeps asking
      drive(1, 0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0);
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1,0,1,8'h40,16'h0, 1,0,0,8'h41,16'h0);
         if (i <= 3) chk("lmax_a", 0, 32'(o_a_gnt[0]), 1);
         if (i == 4) chk("lmax_b", 0, 32'(o_b_gnt[0]), 1);
         chk("lmax_fp_a", 1, 32'(o_a_gnt[1]), 1);
         tick();
      end

      // read granted, then reset in the following cycle
      drive(0, 1,0,0,8'h10,16'h0, 0,0,0,8'h00,16'h0);
      tick();
      drive(1, 1,0,0,8'h10,16'h0, 1,1,0,8'h11,16'h5555);
      chk("rr_rst_rv",   0, 32'(o_a_rv[0]), 0);
      chk("rr_rst_rd",   0, 32'(o_rdata[0]), 0);
      chk("rr_rst_gnt",  0, 32'(o_b_gnt[0]), 0);
      chk("rr_rst_ren",  0, 32'(o_ren[0]), 0);
      tick();
      drive(0, 0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0);
      chk("post_rst_rv", 0, 32'(o_a_rv[0]), 0);
      tick();

      // randomized traffic on a small address window
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 49) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               8'($urandom_range(0, 7)), 16'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               8'($urandom_range(0, 7)), 16'($urandom));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram256x16_arbiter.md
RAM256X16_ARBITER -- requirements
Module: ram256x16_arbiter

Interface
REQ-001 SHALL have parameter: FIXED_PRIO, 0, when 1 port A always wins; when 0 round-robin.
REQ-002 SHALL have parameter: LOCK_MAX, 15, maximum consecutive cycles one port may hold the RAM under lock (1..255).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports:
- RWCLK  in  1  clock; all state on rising edge.
- RESET  in  1  synchronous active-high reset.
- A_REQ, B_REQ  in  1  access request per port.
- A_WE, B_WE  in  1  1 = write, 0 = read.
- A_LOCK, B_LOCK  in  1  request to keep ownership after the current grant (read-modify-write).
- A_ADDR, B_ADDR  in  8  word address.
- A_WD, B_WD  in  16  write data.
- A_GNT, B_GNT  out  1  access accepted this cycle.
- A_RVALID, B_RVALID  out  1  read data valid on RDATA.
- RDATA  out  16  read data, shared by both ports.
- WEN, REN  out  1  RAM write/read enables.
- WADDR, RADDR  out  8  RAM addresses.
- WD  out  16  RAM write data.
- RD  in  16  RAM registered read data (valid the cycle after REN).

Function
REQ-005 Exactly one RAM access SHALL be issued per cycle at most; A_GNT and B_GNT SHALL never both be 1.
REQ-006 Grant SHALL be combinational from current REQ inputs and registered state; GNT=1 in a cycle means the access is performed on that rising edge.
REQ-007 Requesters SHALL hold REQ, WE, ADDR, WD stable until GNT; the arbiter does not buffer requests.
REQ-008 On a granted write: WEN=1, REN=0, WADDR=ADDR, WD=port WD, RADDR=ADDR.
REQ-009 On a granted read: REN=1, WEN=0, RADDR=ADDR, WADDR=ADDR.
REQ-010 With no grant: WEN=0, REN=0; addresses and WD SHALL be 0.
REQ-011 Read latency SHALL be 1 cycle: the x_RVALID of the granted port SHALL be 1 in the cycle after a granted read, and RDATA=RD in that cycle.
REQ-012 RDATA SHALL equal RD whenever either RVALID is 1, and 0 otherwise.
REQ-013 Writes SHALL never assert RVALID.
REQ-014 Round-robin (FIXED_PRIO=0): a LAST register holds the last granted port; when both request, the port not equal to LAST wins; a single requester always wins.
REQ-015 Fixed priority (FIXED_PRIO=1): A wins whenever A_REQ=1, except under a B lock.
REQ-016 Lock FSM states: IDLE, OWN_A, OWN_B.
- IDLE -> OWN_x when x is granted with x_LOCK=1.
- OWN_x: only port x may be granted; other port's GNT=0 regardless of priority.
- OWN_x -> IDLE when x is granted with x_LOCK=0, or a cycle occurs with x_REQ=0 and x_LOCK=0, or the lock counter reaches LOCK_MAX.
REQ-017 Lock counter (8 bits) SHALL clear on entering OWN_x and increment on every cycle spent in OWN_x. On reaching LOCK_MAX it SHALL force IDLE and set LAST=x, so the other port wins the next contention. It SHALL saturate, not wrap.
REQ-018 In OWN_x with x idle, the RAM SHALL be idle (no grant to the other port).
REQ-019 Back-to-back grants SHALL be supported every cycle; RVALID of consecutive reads SHALL follow grants one cycle later with no gaps.
REQ-020 A write followed next cycle by a read to the same address SHALL return the new data (RAM ordering, no bypass needed).

Reset
REQ-021 On RESET=1 at a rising edge: state=IDLE, LAST=B (so A wins first contention), lock counter=0, A_RVALID=B_RVALID=0.
REQ-022 During RESET=1, A_GNT=B_GNT=0 and WEN=REN=0 regardless of requests.
REQ-023 A read granted in the cycle before RESET SHALL NOT produce RVALID after reset.

Verification
REQ-024 Reset, then A_REQ=1, A_WE=1, A_ADDR=0x10, A_WD=0xBEEF -> A_GNT=1, WEN=1, WADDR=0x10, WD=0xBEEF same cycle. Then A read of 0x10 -> A_RVALID=1, RDATA=0xBEEF the next cycle.
REQ-025 Both ports issue continuous reads (FIXED_PRIO=0) -> grants alternate A,B,A,B starting with A. Each RVALID follows its grant by 1 cycle.
REQ-026 FIXED_PRIO=1, both requesting for 4 cycles -> A_GNT=1 all 4 cycles, B_GNT=0.
REQ-027 B granted with B_LOCK=1 (read 0x20), then A_REQ=1 and B write 0x20 with B_LOCK=0 -> B_GNT on both accesses, A_GNT=0 until the cycle after B releases.
REQ-028 LOCK_MAX=3, A holds A_LOCK=1 with continuous requests while B requests -> after 3 locked cycles the FSM returns to IDLE and B_GNT=1 next.
REQ-029 A read granted, RESET asserted the next cycle -> A_RVALID=0, and all outputs at reset values during reset.
